frame_switch_ctrl: RTL and testbench

- Avalon-MM slave that drives NUM_CH buffer/path-select switch lines on a conduit.
- Supersedes the fixed two-switch, write-only controller. Adds:
  - parametrised channel count
  - register readback
  - frame-synchronous (shadowed) updates
  - automatic ping-pong toggling per frame
  - a frame counter and a frame interrupt
- Sits between the Nios/HPS bus and the video frame-buffer muxes. Switching happens only on frame boundaries, so no frame is torn.

---
 rtl/frame_ctrl_pkg.sv | 32 +++
 rtl/frame_switch_ctrl_pulse_sync.sv | 39 +++
 rtl/frame_switch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_frame_switch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// frame_ctrl_pkg
//   Shared definitions for the frame-synchronous switch controller:
//   register word addresses, CTRL bit layout and STATUS field positions.
// ---------------------------------------------------------------------------
package frame_ctrl_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_SW     = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL register bit indices
  localparam int CTRL_SYNC_EN     = 0;
  localparam int CTRL_AUTO_TOGGLE = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int CTRL_W           = 3;

  // CTRL register as a packed struct; member order gives bit0 = sync_en
  typedef struct packed {
    logic irq_en;       // bit 2
    logic auto_toggle;  // bit 1
    logic sync_en;      // bit 0
  } ctrl_t;

  // STATUS register layout
  localparam int STAT_PENDING  = 0;
  localparam int STAT_IRQ_FLAG = 1;
  localparam int STAT_FCNT_LSB = 16;

endpackage

// File: rtl/frame_switch_ctrl_pulse_sync.sv
// ---------------------------------------------------------------------------
// pulse_sync
//   Brings an asynchronous level strobe into the csi_clk domain through a
//   SYNC_STAGES-deep flop chain and emits a one-cycle pulse on each rising
//   edge of the synchronised level. The pulse is acted on by the consumer at
//   the (SYNC_STAGES+1)-th clock edge after the input rises.
//
// Ports:
//   csi_clk      in   system clock
//   rsi_reset_n  in   asynchronous active-low reset
//   async_in     in   asynchronous strobe (high for >= 2 clock cycles)
//   pulse        out  one-cycle rising-edge pulse, csi_clk domain
// ---------------------------------------------------------------------------
module pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic csi_clk,
  input  logic rsi_reset_n,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Decoded from registers only, so it is clean within the clock domain.
  assign pulse = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/frame_switch_ctrl.sv
// ---------------------------------------------------------------------------
// frame_switch_ctrl
//   Avalon-MM slave driving NUM_CH frame-buffer/path-select switch lines.
//   Switch updates can be applied immediately or deferred (shadowed) to the
//   next frame boundary, the lines can ping-pong automatically every frame,
//   frames are counted, and a level interrupt flags each frame boundary.
//
// Ports:
//   csi_clk            in   system clock
//   rsi_reset_n        in   asynchronous active-low reset
//   avs_s0_address     in   word address (SW, CTRL, TOGGLE_MASK, STATUS)
//   avs_s0_write       in   write strobe
//   avs_s0_writedata   in   write data
//   avs_s0_read        in   read strobe
//   avs_s0_readdata    out  registered read data, valid 1 cycle after read
//   coe_c0_frame_sync  in   asynchronous frame boundary strobe
//   coe_c0_sw          out  switch lines
//   ins_irq0_irq       out  frame interrupt (level)
// ---------------------------------------------------------------------------
module frame_switch_ctrl
  import frame_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int FCNT_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  input  logic [1:0]        avs_s0_address,
  input  logic              avs_s0_write,
  input  logic [31:0]       avs_s0_writedata,
  input  logic              avs_s0_read,
  output logic [31:0]       avs_s0_readdata,
  input  logic              coe_c0_frame_sync,
  output logic [NUM_CH-1:0] coe_c0_sw,
  output logic              ins_irq0_irq
);

  logic [NUM_CH-1:0] sw_reg,       sw_next;
  logic [NUM_CH-1:0] shadow_reg,   shadow_next;
  logic [NUM_CH-1:0] mask_reg,     mask_next;
  logic              pending_reg,  pending_next;
  ctrl_t             ctrl_reg,     ctrl_next;
  logic [FCNT_W-1:0] fcnt_reg,     fcnt_next;
  logic              irq_flag_reg, irq_flag_next;
  logic [31:0]       readdata_reg, readdata_next;

  logic        fs_pulse;
  logic        wr_sw, wr_ctrl, wr_mask, wr_status;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  pulse_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_frame_sync (
    .csi_clk     (csi_clk),
    .rsi_reset_n (rsi_reset_n),
    .async_in    (coe_c0_frame_sync),
    .pulse       (fs_pulse)
  );

  assign wr_sw     = avs_s0_write && (avs_s0_address == ADDR_SW);
  assign wr_ctrl   = avs_s0_write && (avs_s0_address == ADDR_CTRL);
  assign wr_mask   = avs_s0_write && (avs_s0_address == ADDR_MASK);
  assign wr_status = avs_s0_write && (avs_s0_address == ADDR_STATUS);

  // Only the low bits of writedata carry register content.
  assign unused_wdata = ^avs_s0_writedata;

  // Readback mux works on current register values, so a read in the same
  // cycle as a write returns the pre-write contents.
  always_comb begin
    rd_mux = '0;
    case (avs_s0_address)
      ADDR_SW:     rd_mux[NUM_CH-1:0] = sw_reg;
      ADDR_CTRL:   rd_mux[CTRL_W-1:0] = ctrl_reg;
      ADDR_MASK:   rd_mux[NUM_CH-1:0] = mask_reg;
      ADDR_STATUS: begin
        rd_mux[STAT_PENDING]              = pending_reg;
        rd_mux[STAT_IRQ_FLAG]             = irq_flag_reg;
        rd_mux[STAT_FCNT_LSB +: FCNT_W]   = fcnt_reg;
      end
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    sw_next       = sw_reg;
    shadow_next   = shadow_reg;
    pending_next  = pending_reg;
    ctrl_next     = ctrl_reg;
    mask_next     = mask_reg;
    fcnt_next     = fcnt_reg;
    irq_flag_next = irq_flag_reg;
    readdata_next = readdata_reg;

    if (avs_s0_read) begin
      readdata_next = rd_mux;
    end

    // Switch update. A write landing on a frame boundary with SYNC_EN set
    // would be applied at that very boundary anyway, so it goes straight to
    // sw and nothing is left pending. A pending value left behind when
    // SYNC_EN is cleared is flushed immediately rather than waiting for a
    // frame that may never be synchronised again.
    if (wr_sw) begin
      if (!ctrl_reg.sync_en || fs_pulse) begin
        sw_next      = avs_s0_writedata[NUM_CH-1:0];
        pending_next = 1'b0;
      end else begin
        shadow_next  = avs_s0_writedata[NUM_CH-1:0];
        pending_next = 1'b1;
      end
    end else if (pending_reg && !ctrl_reg.sync_en) begin
      sw_next      = shadow_reg;
      pending_next = 1'b0;
    end else if (fs_pulse) begin
      // A freshly loaded value takes precedence over the ping-pong toggle.
      if (pending_reg) begin
        sw_next      = shadow_reg;
        pending_next = 1'b0;
      end else if (ctrl_reg.auto_toggle) begin
        sw_next = sw_reg ^ mask_reg;
      end
    end

    if (wr_ctrl) begin
      ctrl_next = ctrl_t'(avs_s0_writedata[CTRL_W-1:0]);
    end
    if (wr_mask) begin
      mask_next = avs_s0_writedata[NUM_CH-1:0];
    end

    if (fs_pulse) begin
      fcnt_next = fcnt_reg + FCNT_W'(1);
    end

    // Set wins over a write-1-to-clear on the same edge, so no frame
    // event is lost to a racing acknowledge.
    if (fs_pulse && ctrl_reg.irq_en) begin
      irq_flag_next = 1'b1;
    end else if (wr_status && avs_s0_writedata[STAT_IRQ_FLAG]) begin
      irq_flag_next = 1'b0;
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      sw_reg       <= '0;
      shadow_reg   <= '0;
      mask_reg     <= '0;
      pending_reg  <= 1'b0;
      ctrl_reg     <= '0;
      fcnt_reg     <= '0;
      irq_flag_reg <= 1'b0;
      readdata_reg <= '0;
    end else begin
      sw_reg       <= sw_next;
      shadow_reg   <= shadow_next;
      mask_reg     <= mask_next;
      pending_reg  <= pending_next;
      ctrl_reg     <= ctrl_next;
      fcnt_reg     <= fcnt_next;
      irq_flag_reg <= irq_flag_next;
      readdata_reg <= readdata_next;
    end
  end

  assign coe_c0_sw       = sw_reg;
  assign avs_s0_readdata = readdata_reg;
  assign ins_irq0_irq    = irq_flag_reg & ctrl_reg.irq_en;

endmodule

// File: tb/tb_frame_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frame_switch_ctrl
//   Directed walk through the register map and frame behaviour followed by
//   randomized bus traffic, frame strobes and resets, all compared against a
//   per-clock-edge reference model of the register rules.
// ---------------------------------------------------------------------------
module tb_frame_switch_ctrl;

  localparam int NUM_CH      = 2;
  localparam int FCNT_W      = 2;
  localparam int SYNC_STAGES = 2;

  logic              csi_clk;
  logic              rsi_reset_n;
  logic [1:0]        avs_s0_address;
  logic              avs_s0_write;
  logic [31:0]       avs_s0_writedata;
  logic              avs_s0_read;
  logic [31:0]       avs_s0_readdata;
  logic              coe_c0_frame_sync;
  logic [NUM_CH-1:0] coe_c0_sw;
  logic              ins_irq0_irq;

  frame_switch_ctrl #(
    .NUM_CH      (NUM_CH),
    .FCNT_W      (FCNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .csi_clk           (csi_clk),
    .rsi_reset_n       (rsi_reset_n),
    .avs_s0_address    (avs_s0_address),
    .avs_s0_write      (avs_s0_write),
    .avs_s0_writedata  (avs_s0_writedata),
    .avs_s0_read       (avs_s0_read),
    .avs_s0_readdata   (avs_s0_readdata),
    .coe_c0_frame_sync (coe_c0_frame_sync),
    .coe_c0_sw         (coe_c0_sw),
    .ins_irq0_irq      (ins_irq0_irq)
  );

  initial csi_clk = 1'b0;
  always #5 csi_clk = ~csi_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned       frame_mod = 1 << FCNT_W;
  logic [NUM_CH-1:0] m_sw, m_shadow, m_mask;
  logic              m_pending, m_irq;
  logic [2:0]        m_ctrl;     // {irq_en, auto_toggle, sync_en}
  int unsigned       m_fcnt;
  logic [31:0]       m_rdata;
  // frame_sync value driven before each edge; bit k = k edges ago
  logic [SYNC_STAGES+1:0] fs_hist;
  logic              fs_level;

  function automatic logic [31:0] m_status();
    return (32'(m_fcnt) << 16) | (32'(m_irq) << 1) | 32'(m_pending);
  endfunction

  task automatic model_reset();
    m_sw = '0; m_shadow = '0; m_mask = '0; m_pending = 1'b0; m_irq = 1'b0;
    m_ctrl = '0; m_fcnt = 0; m_rdata = '0; fs_hist = '0;
  endtask

  // Apply one clock edge worth of spec rules, reading only the pre-edge state.
  task automatic model_edge(input logic wr, input logic [1:0] a, input logic [31:0] wd,
                            input logic rd, input logic frame);
    logic [NUM_CH-1:0] n_sw, n_shadow, n_mask;
    logic              n_pending, n_irq;
    logic [2:0]        n_ctrl;
    logic              sync_en, auto_tg, irq_en;
    sync_en = m_ctrl[0]; auto_tg = m_ctrl[1]; irq_en = m_ctrl[2];
    if (rd) begin
      case (a)
        2'd0:    m_rdata = 32'(m_sw);
        2'd1:    m_rdata = 32'(m_ctrl);
        2'd2:    m_rdata = 32'(m_mask);
        default: m_rdata = m_status();
      endcase
    end
    n_sw = m_sw; n_shadow = m_shadow; n_mask = m_mask; n_pending = m_pending;
    n_irq = m_irq; n_ctrl = m_ctrl;
    if (wr && a == 2'd0 && (!sync_en || frame)) begin
      n_sw = wd[NUM_CH-1:0];           // immediate, or written right at a boundary
      n_pending = 1'b0;
    end else if (wr && a == 2'd0) begin
      n_shadow = wd[NUM_CH-1:0];       // deferred; last write wins
      n_pending = 1'b1;
    end else if (m_pending && !sync_en) begin
      n_sw = m_shadow;                 // sync disabled with an update waiting
      n_pending = 1'b0;
    end else if (frame && m_pending) begin
      n_sw = m_shadow;
      n_pending = 1'b0;
    end else if (frame && auto_tg) begin
      n_sw = m_sw ^ m_mask;
    end
    if (wr && a == 2'd1) n_ctrl = wd[2:0];
    if (wr && a == 2'd2) n_mask = wd[NUM_CH-1:0];
    if (frame) m_fcnt = (m_fcnt + 1) % frame_mod;
    if (frame && irq_en) n_irq = 1'b1;
    else if (wr && a == 2'd3 && wd[1]) n_irq = 1'b0;
    m_sw = n_sw; m_shadow = n_shadow; m_mask = n_mask; m_pending = n_pending;
    m_irq = n_irq; m_ctrl = n_ctrl;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic wr, input logic [1:0] a, input logic [31:0] wd,
                      input logic rd);
    logic frame;
    @(negedge csi_clk);
    avs_s0_write      = wr;
    avs_s0_address    = a;
    avs_s0_writedata  = wd;
    avs_s0_read       = rd;
    coe_c0_frame_sync = fs_level;
    fs_hist = {fs_hist[SYNC_STAGES:0], fs_level};
    // a rising input edge is acted on SYNC_STAGES+1 edges after it is driven
    frame = fs_hist[SYNC_STAGES] & ~fs_hist[SYNC_STAGES+1];
    @(posedge csi_clk);
    model_edge(wr, a, wd, rd, frame);
    #1;
    if (wr || rd)
      $display("t=%0t wr=%0b rd=%0b addr=%0d wdata=0x%08h rdata=0x%08h sw=0x%0h irq=%0b frame=%0b",
               $time, wr, rd, a, wd, avs_s0_readdata, coe_c0_sw, ins_irq0_irq, frame);
    check("sw", 32'(coe_c0_sw), 32'(m_sw));
    check("irq", 32'(ins_irq0_irq), 32'(m_irq & m_ctrl[2]));
    check("rdata", avs_s0_readdata, m_rdata);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    tick(1'b1, a, d, 1'b0);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    tick(1'b0, a, 32'h0, 1'b1);
  endtask

  task automatic idle();
    tick(1'b0, 2'd0, 32'h0, 1'b0);
  endtask

  task automatic frame_pulse();
    fs_level = 1'b1;
    repeat (3) idle();
    fs_level = 1'b0;
    repeat (SYNC_STAGES + 2) idle();
  endtask

  task automatic do_reset();
    @(negedge csi_clk);
    #2;
    avs_s0_write = 1'b0; avs_s0_read = 1'b0;
    fs_level = 1'b0; coe_c0_frame_sync = 1'b0;
    rsi_reset_n = 1'b0;
    #1;
    model_reset();
    // asynchronous clear is visible before any clock edge
    check("rst_sw", 32'(coe_c0_sw), 32'h0);
    check("rst_irq", 32'(ins_irq0_irq), 32'h0);
    check("rst_rdata", avs_s0_readdata, 32'h0);
    repeat (2) @(negedge csi_clk);
    rsi_reset_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int fs_cnt;
    int r;
    rsi_reset_n = 1'b1;
    avs_s0_address = '0; avs_s0_write = 1'b0; avs_s0_writedata = '0; avs_s0_read = 1'b0;
    coe_c0_frame_sync = 1'b0; fs_level = 1'b0;
    model_reset();
    do_reset();

    // all registers read back zero after reset
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i));
      check("reset_read", avs_s0_readdata, 32'h0);
    end

    // immediate update
    wr_reg(2'd1, 32'h0);
    wr_reg(2'd0, 32'h3);
    check("direct_sw", 32'(coe_c0_sw), 32'h3);
    rd_reg(2'd0);
    check("direct_read", avs_s0_readdata, 32'h3);
    rd_reg(2'd3);
    check("direct_pending", avs_s0_readdata, 32'h0);

    // shadowed update and its latency
    wr_reg(2'd1, 32'h1);
    wr_reg(2'd0, 32'h1);
    check("shadow_hold", 32'(coe_c0_sw), 32'h3);
    rd_reg(2'd3);
    check("shadow_pending", avs_s0_readdata, 32'h1);
    fs_level = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
      idle();
      if (k == SYNC_STAGES) check("lat_before", 32'(coe_c0_sw), 32'h3);
    end
    check("lat_apply", 32'(coe_c0_sw), 32'h1);
    fs_level = 1'b0;
    repeat (SYNC_STAGES + 2) idle();
    rd_reg(2'd3);
    check("shadow_status", avs_s0_readdata, 32'h0001_0000);

    // auto toggle ping-pong
    wr_reg(2'd1, 32'h2);
    wr_reg(2'd2, 32'h3);
    frame_pulse(); check("toggle1", 32'(coe_c0_sw), 32'h2);
    frame_pulse(); check("toggle2", 32'(coe_c0_sw), 32'h1);
    frame_pulse(); check("toggle3", 32'(coe_c0_sw), 32'h2);
    rd_reg(2'd3);
    check("toggle_fcnt", avs_s0_readdata, 32'h0000_0000);  // 4 frames wrap to 0 at FCNT_W=2

    // pending beats toggle; interrupt set / clear / set-wins
    wr_reg(2'd1, 32'h7);
    wr_reg(2'd0, 32'h0);
    frame_pulse();
    check("pend_no_toggle", 32'(coe_c0_sw), 32'h0);
    check("irq_set", 32'(ins_irq0_irq), 32'h1);
    wr_reg(2'd3, 32'h2);
    check("irq_clear", 32'(ins_irq0_irq), 32'h0);
    fs_level = 1'b1;
    for (int k = 1; k <= SYNC_STAGES; k++) idle();
    wr_reg(2'd3, 32'h2);   // clear on the same edge as the frame pulse
    check("irq_set_wins", 32'(ins_irq0_irq), 32'h1);
    fs_level = 1'b0;
    repeat (SYNC_STAGES + 2) idle();
    rd_reg(2'd1);
    check("ctrl_read", avs_s0_readdata, 32'h7);

    // frame counter wrap from reset, then reset discards pending
    do_reset();
    repeat (5) frame_pulse();
    rd_reg(2'd3);
    check("fcnt_wrap", avs_s0_readdata, 32'h0001_0000);
    wr_reg(2'd0, 32'h3);
    wr_reg(2'd1, 32'h1);
    wr_reg(2'd0, 32'h2);
    rd_reg(2'd3);
    check("pend_before_rst", avs_s0_readdata, 32'h0001_0001);
    do_reset();
    rd_reg(2'd3);
    check("pend_after_rst", avs_s0_readdata, 32'h0);
    check("sw_after_rst", 32'(coe_c0_sw), 32'h0);

    // randomized traffic
    fs_cnt = 3;
    for (int n = 0; n < 1500; n++) begin
      if (fs_cnt == 0) begin
        fs_level = ~fs_level;
        fs_cnt = fs_level ? int'($urandom_range(2, 4)) : int'($urandom_range(SYNC_STAGES + 2, 9));
      end
      fs_cnt--;
      r = int'($urandom_range(0, 9));
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        fs_cnt = 3;
      end else if (r < 4) begin
        wr_reg(2'($urandom_range(0, 3)), $urandom);
      end else if (r < 7) begin
        rd_reg(2'($urandom_range(0, 3)));
      end else if (r == 7) begin
        tick(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b1);
      end else begin
        idle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // safety net against a stalled run
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
